// File: rtl/pipelined_iir_sos.sv
// Cascaded Direct Form I biquad filter, NSEC sections, evaluated serially on
// one shared signed multiplier (5 MAC cycles per section) with a wide
// accumulator. Each section output is rounded half-up and saturated to DW.
module pipelined_iir_sos #(
  parameter int DW   = 32,
  parameter int CW   = 32,
  parameter int FRAC = 20,
  parameter int NSEC = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [DW-1:0]           x,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           bypass,
  input  logic                           clear_state,
  input  logic                           coef_we,
  input  logic [$clog2(5*NSEC)-1:0]      coef_addr,
  input  logic signed [CW-1:0]           coef_wdata,
  output logic                           coef_err,
  output logic signed [DW-1:0]           y,
  output logic                           out_valid
);

  localparam int NCOEF = 5 * NSEC;
  localparam int AW    = $clog2(NCOEF);
  localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int PW    = DW + CW;
  localparam int ACCW  = DW + CW + 4;

  localparam logic [AW:0]              NCOEF_L = (AW + 1)'(NCOEF);
  localparam logic signed [CW-1:0]     ONE     = CW'(1) << FRAC;
  localparam logic signed [ACCW-1:0]   HALF    = ACCW'(1) << (FRAC - 1);
  localparam logic signed [ACCW-1:0]   SAT_HI  = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0]   SAT_LO  = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0]     Y_MAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]     Y_MIN   = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_reg;
  logic [AW-1:0]           cnt_reg;
  logic [SW-1:0]           sec_reg;
  logic [2:0]              k_reg;
  logic signed [ACCW-1:0]  acc_reg;
  logic signed [DW-1:0]    u_reg;
  logic signed [DW-1:0]    y_reg;
  logic                    bypass_reg;
  logic                    out_valid_reg;
  logic                    coef_err_reg;

  logic signed [CW-1:0]    coef_bank [NCOEF];
  logic signed [DW-1:0]    u1_hist [NSEC];
  logic signed [DW-1:0]    u2_hist [NSEC];
  logic signed [DW-1:0]    v1_hist [NSEC];
  logic signed [DW-1:0]    v2_hist [NSEC];

  logic signed [CW-1:0]    coef_sel;
  logic signed [DW-1:0]    op;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  term;
  logic signed [ACCW-1:0]  acc_base;
  logic signed [ACCW-1:0]  acc_next;
  logic signed [ACCW-1:0]  rnd;
  logic signed [ACCW-1:0]  shifted;
  logic signed [DW-1:0]    v_q;
  logic                    coef_ok;
  logic                    sec_end;

  // A write is legal only while idle and to an existing coefficient slot.
  assign coef_ok  = (state_reg == IDLE) && ({1'b0, coef_addr} < NCOEF_L);
  // Last MAC cycle of a section: histories shift and the section output forms.
  assign sec_end  = (state_reg == RUN) && (k_reg == 3'd4);

  assign in_ready  = (state_reg == IDLE);
  assign y         = y_reg;
  assign out_valid = out_valid_reg;
  assign coef_err  = coef_err_reg;

  genvar gi;

  // Coefficient bank: one register per slot, identity filter after reset.
  generate
    for (gi = 0; gi < NCOEF; gi++) begin : g_coef
      localparam logic signed [CW-1:0] INIT = ((gi % 5) == 0) ? ONE : '0;
      logic signed [CW-1:0] c_reg;

      // Load identity on reset, otherwise take legal writes to this slot.
      always_ff @(posedge clk) begin
        if (reset) begin
          c_reg <= INIT;
        end else if (coef_we && coef_ok && (coef_addr == AW'(gi))) begin
          c_reg <= coef_wdata;
        end
      end

      assign coef_bank[gi] = c_reg;
    end
  endgenerate

  // Per-section input/output history (two taps each).
  generate
    for (gi = 0; gi < NSEC; gi++) begin : g_sec
      logic signed [DW-1:0] u1_reg, u2_reg, v1_reg, v2_reg;

      // Clear on reset or idle clear request; shift at the end of this section.
      always_ff @(posedge clk) begin
        if (reset || ((state_reg == IDLE) && clear_state)) begin
          u1_reg <= '0;
          u2_reg <= '0;
          v1_reg <= '0;
          v2_reg <= '0;
        end else if (sec_end && (sec_reg == SW'(gi))) begin
          u2_reg <= u1_reg;
          u1_reg <= u_reg;
          v2_reg <= v1_reg;
          v1_reg <= v_q;
        end
      end

      assign u1_hist[gi] = u1_reg;
      assign u2_hist[gi] = u2_reg;
      assign v1_hist[gi] = v1_reg;
      assign v2_hist[gi] = v2_reg;
    end
  endgenerate

  // Shared MAC datapath: pick tap operand, multiply, accumulate, quantise.
  always_comb begin
    coef_sel = coef_bank[cnt_reg];
    op       = '0;
    case (k_reg)
      3'd0:    op = u_reg;
      3'd1:    op = u1_hist[sec_reg];
      3'd2:    op = u2_hist[sec_reg];
      3'd3:    op = v1_hist[sec_reg];
      3'd4:    op = v2_hist[sec_reg];
      default: op = '0;
    endcase
    prod     = coef_sel * op;
    prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
    // Feedback taps (a1, a2) are subtracted.
    term     = (k_reg >= 3'd3) ? -prod_ext : prod_ext;
    // The accumulator restarts at the first tap of every section.
    acc_base = (k_reg == 3'd0) ? '0 : acc_reg;
    acc_next = acc_base + term;
    rnd      = acc_next + HALF;
    shifted  = rnd >>> FRAC;
    if (shifted > SAT_HI) begin
      v_q = Y_MAX;
    end else if (shifted < SAT_LO) begin
      v_q = Y_MIN;
    end else begin
      v_q = shifted[DW-1:0];
    end
  end

  // Control FSM: accept a sample, run NSEC*5 MAC cycles (or bypass), emit y.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sec_reg       <= '0;
      k_reg         <= '0;
      acc_reg       <= '0;
      u_reg         <= '0;
      y_reg         <= '0;
      bypass_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      coef_err_reg  <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      coef_err_reg  <= coef_we && !coef_ok;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            u_reg      <= x;
            bypass_reg <= bypass;
            cnt_reg    <= '0;
            sec_reg    <= '0;
            k_reg      <= '0;
            state_reg  <= bypass ? DONE : RUN;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + AW'(1);
          if (k_reg == 3'd4) begin
            // Section output becomes the next section's input.
            u_reg   <= v_q;
            k_reg   <= '0;
            sec_reg <= sec_reg + SW'(1);
            if (sec_reg == SW'(NSEC - 1)) begin
              y_reg         <= v_q;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end else begin
            k_reg <= k_reg + 3'd1;
          end
        end
        DONE: begin
          if (bypass_reg) begin
            y_reg         <= u_reg;
            out_valid_reg <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pipelined_iir_sos.md
PIPELINED_IIR_SOS -- requirements
Module: pipelined_iir_sos

Interface
Parameters:
REQ-001 SHALL provide DW, default 32: signed sample width of x and y.
REQ-002 SHALL provide CW, default 32: signed coefficient width.
REQ-003 SHALL provide FRAC, default 20: coefficient fraction bits; 1.0 = 1048576.
REQ-004 SHALL provide NSEC, default 6: number of cascaded biquad sections (order 2*NSEC).

Ports:
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 x  in  DW  signed input sample.
REQ-008 in_valid  in  1  x is valid this cycle.
REQ-009 in_ready  out  1  block can accept a sample.
REQ-010 bypass  in  1  sampled with x; 1 = pass x through unfiltered.
REQ-011 clear_state  in  1  zero all section histories (honoured in IDLE only).
REQ-012 coef_we  in  1  coefficient write strobe.
REQ-013 coef_addr  in  clog2(5*NSEC)  address = 5*section + k; k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
REQ-014 coef_wdata  in  CW  signed coefficient value.
REQ-015 coef_err  out  1  one-cycle pulse: write rejected.
REQ-016 y  out  DW  signed filtered output, held until the next output.
REQ-017 out_valid  out  1  one-cycle pulse: y is new.

Function
REQ-018 Each section SHALL compute Direct Form I: v = b0*u + b1*u1 + b2*u2 - a1*v1 - a2*v2, where u = section input and u1/u2/v1/v2 = that section's history.
REQ-019 Section s>0 input SHALL be the quantised output of section s-1; the output of section NSEC-1 SHALL be y.
REQ-020 Arithmetic SHALL use one shared signed multiplier and an accumulator of DW+CW+4 bits, time-multiplexed with 5 MAC cycles per section.
REQ-021 Section quantisation: (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift), then saturate to [-2^(DW-1), 2^(DW-1)-1]. The accumulator SHALL clear at the start of each section.
REQ-022 FSM states SHALL be IDLE, RUN, DONE.
  - IDLE -> RUN on in_valid && in_ready && !bypass.
  - IDLE -> DONE on in_valid && in_ready && bypass.
  - RUN -> DONE after exactly 5*NSEC cycles.
  - DONE -> IDLE unconditionally.
REQ-023 in_ready SHALL be 1 only in IDLE; in_valid in RUN or DONE SHALL be ignored (no sample loss accounting).
REQ-024 Latency: for a sample accepted at edge E, y/out_valid SHALL appear after edge E+5*NSEC (filtered) or E+1 (bypass). Throughput SHALL be one sample per 5*NSEC+2 cycles.
REQ-025 Histories SHALL update (u2<=u1, u1<=u, v2<=v1, v1<=v) only at the end of each section in a filtered run. Bypass SHALL leave histories unchanged.
REQ-026 Bypass output SHALL be y = x exactly.
REQ-027 coef_we in IDLE SHALL write the addressed coefficient at that edge, with the new value in effect for the next accepted sample.
REQ-028 coef_we in RUN/DONE, or with coef_addr >= 5*NSEC, SHALL be ignored and SHALL pulse coef_err next cycle.
REQ-029 coef_we and in_valid in the same IDLE cycle: the write SHALL complete first, so the accepted sample uses the new coefficient.
REQ-030 clear_state in IDLE SHALL zero all histories at that edge; if in_valid is also high, the sample SHALL be accepted and processed with zeroed history. clear_state outside IDLE SHALL be ignored.

Reset
REQ-031 While reset is high at an edge: state IDLE, in_ready=1, out_valid=0, coef_err=0, y=0, all histories 0, accumulator 0.
REQ-032 Reset SHALL load identity coefficients in every section: b0=2^FRAC, b1=b2=a1=a2=0.
REQ-033 Reset mid-RUN SHALL abort the run with no out_valid and no history update.

Verification (NSEC=6, FRAC=20, DW=32)
REQ-034 Reset, then x=524288 accepted at edge E -> out_valid after edge E+30, y=524288; in_ready=0 for 31 cycles.
REQ-035 Write sec0 b0=524288, then x=1048576 -> y=524288; then x=3 -> y=2 (round half-up).
REQ-036 Write sec0 b0=4194304 (4.0) and sec1 b0=4194304, then x=1073741824 -> y=2147483647; x=-1073741824 -> y=-2147483648.
REQ-037 Sec0 a1=-524288, then impulse x=1048576 followed by 0,0 -> y = 1048576, 524288, 262144; after clear_state, next x=0 -> y=0.
REQ-038 coef_we during RUN -> coef_err pulse and coefficient unchanged; in_valid during RUN ignored; bypass x=-271391 -> y=-271391 one edge after acceptance.
REQ-039 Assert reset at RUN cycle 10 -> no out_valid; in_ready=1 the next cycle; identity coefficients restored.
